huffman_encoder: RTL



---
 rtl/huffman_encoder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/huffman_encoder.sv
// Serial Huffman encoder: 3-bit symbols in over valid/ready, prefix codes out MSB-first, one bit per clock.
// Define HUFF_BACK2BACK_EN to also accept a symbol during the last bit of a code (gapless output).
module huffman_encoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       sym_in,
    input  logic             sym_valid,
    output logic             sym_ready,
    output logic             x,
    output logic             x_valid,
    output logic             err,
    output logic [CNT_W-1:0] sym_cnt
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_reg, state_next;
    logic [2:0]       shift_reg, shift_next;
    logic [1:0]       bit_cnt_reg, bit_cnt_next;
    logic             x_reg, x_next;
    logic             x_valid_reg, x_valid_next;
    logic             err_reg, err_next;
    logic [CNT_W-1:0] sym_cnt_reg, sym_cnt_next;

    logic [3:0] code_bits;
    logic [1:0] code_last;
    logic       code_legal;
    logic       last_bit;
    logic       accept;

    // Codes are left-aligned in code_bits; code_last is the code length minus one.
    always_comb begin
        code_bits  = 4'b0000;
        code_last  = 2'd0;
        code_legal = 1'b1;
        case (sym_in)
            3'd1:    begin code_bits = 4'b0000; code_last = 2'd0; end
            3'd3:    begin code_bits = 4'b1000; code_last = 2'd2; end
            3'd2:    begin code_bits = 4'b1010; code_last = 2'd2; end
            3'd4:    begin code_bits = 4'b1110; code_last = 2'd2; end
            3'd6:    begin code_bits = 4'b1100; code_last = 2'd3; end
            3'd5:    begin code_bits = 4'b1101; code_last = 2'd3; end
            default: code_legal = 1'b0;
        endcase
    end

    assign last_bit = (state_reg == SHIFT) && (bit_cnt_reg == 2'd0);

`ifdef HUFF_BACK2BACK_EN
    assign sym_ready = !reset && ((state_reg == IDLE) || last_bit);
`else
    assign sym_ready = !reset && (state_reg == IDLE);
`endif

    assign accept = sym_valid && sym_ready;

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        x_next       = 1'b0;
        x_valid_next = 1'b0;
        err_next     = 1'b0;
        sym_cnt_next = sym_cnt_reg;

        if (state_reg == SHIFT && bit_cnt_reg != 2'd0) begin
            x_next       = shift_reg[2];
            x_valid_next = 1'b1;
            shift_next   = {shift_reg[1:0], 1'b0};
            bit_cnt_next = bit_cnt_reg - 2'd1;
        end else if (state_reg == SHIFT) begin
            state_next = IDLE;
        end

        // An accept can only happen when no bits remain, so it safely overrides the shift path.
        if (accept) begin
            if (code_legal) begin
                x_next       = code_bits[3];
                x_valid_next = 1'b1;
                shift_next   = code_bits[2:0];
                bit_cnt_next = code_last;
                sym_cnt_next = sym_cnt_reg + CNT_W'(1);
                state_next   = (code_last == 2'd0) ? IDLE : SHIFT;
            end else begin
                x_next       = 1'b0;
                x_valid_next = 1'b0;
                err_next     = 1'b1;
                shift_next   = 3'b000;
                bit_cnt_next = 2'd0;
                state_next   = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            shift_reg   <= 3'b000;
            bit_cnt_reg <= 2'd0;
            x_reg       <= 1'b0;
            x_valid_reg <= 1'b0;
            err_reg     <= 1'b0;
            sym_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            x_reg       <= x_next;
            x_valid_reg <= x_valid_next;
            err_reg     <= err_next;
            sym_cnt_reg <= sym_cnt_next;
        end
    end

    assign x       = x_reg;
    assign x_valid = x_valid_reg;
    assign err     = err_reg;
    assign sym_cnt = sym_cnt_reg;

endmodule
